dec_scan_n: RTL
===============

DEC_SCAN_N -- requirements
Module: dec_scan_n

Interface
REQ-001 The block SHALL take parameter SEL_W, default 4, as the select width; legal range 1..6.
REQ-002 The block SHALL take parameter DIV_W, default 8, as the scan prescaler width; legal range 1..16.
REQ-003 The block SHALL derive OUT_W = 2**SEL_W internally; it SHALL NOT be a separate parameter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 en  input  1  enable; 0 forces outputs inactive and freezes state.
REQ-007 mode  input  2  00 DIRECT, 01 SCAN_UP, 10 SCAN_DOWN, 11 HOLD.
REQ-008 sel  input  SEL_W  decode select in DIRECT; start index for load in scan modes.
REQ-009 load  input  1  in SCAN_UP/SCAN_DOWN, loads sel into the index.
REQ-010 div  input  DIV_W  scan step period minus one, in enabled cycles.
REQ-011 out  output  OUT_W  registered one-hot decode of idx; all zero when disabled.
REQ-012 idx  output  SEL_W  current registered index.
REQ-013 wrap  output  1  one-cycle pulse on index wrap-around in scan modes.

Function
REQ-014 All outputs SHALL be registered; no combinational path SHALL exist from inputs to outputs.
REQ-015 When en=1, out SHALL equal the one-hot code of idx: bit idx set, all other bits clear.
REQ-016 When en=0, on the next edge out SHALL become all zero, wrap SHALL become 0, and idx and the prescaler SHALL hold.
REQ-017 DIRECT with en=1: idx SHALL load sel every cycle, and out SHALL reflect sel one cycle later (latency 1).
REQ-018 DIRECT: the prescaler SHALL be held at 0, and wrap SHALL be 0.
REQ-019 SCAN_UP/SCAN_DOWN with en=1 and load=0: the prescaler SHALL count 0..div; when it equals div, it SHALL return to 0 and idx SHALL step.
REQ-020 div=0 SHALL step idx every enabled cycle; in general the step period SHALL be div+1 enabled cycles.
REQ-021 SCAN_UP step SHALL be idx+1 modulo OUT_W; the transition OUT_W-1 -> 0 SHALL assert wrap for exactly that cycle.
REQ-022 SCAN_DOWN step SHALL be idx-1 modulo OUT_W; the transition 0 -> OUT_W-1 SHALL assert wrap for exactly that cycle.
REQ-023 load=1 in a scan mode with en=1: idx SHALL take sel, the prescaler SHALL clear to 0, and wrap SHALL be 0; load SHALL take priority over a step due the same cycle.
REQ-024 load SHALL be ignored in DIRECT and HOLD.
REQ-025 HOLD with en=1: idx and the prescaler SHALL freeze, out SHALL keep the one-hot code of idx, and wrap SHALL be 0.
REQ-026 Any change of mode between consecutive enabled cycles SHALL clear the prescaler to 0; idx SHALL be kept, except that entry into DIRECT loads sel.
REQ-027 A change to div mid-period SHALL take effect on the next compare; if the prescaler exceeds the new div, the prescaler SHALL wrap to 0 and step on that cycle.
REQ-028 SEL_W=1 SHALL behave as a 1-to-2 decoder; every scan step SHALL then assert wrap.

Reset
REQ-029 reset=1 SHALL on the next edge set idx=0, prescaler=0, out=0 and wrap=0, regardless of en, mode and load.
REQ-030 reset SHALL take priority over all other inputs.
REQ-031 Reset asserted mid-scan SHALL abandon the current period; the first step after release SHALL occur div+1 enabled cycles later.
REQ-032 While reset=1, out SHALL remain all zero.

Verification
REQ-033 DIRECT, en=1, sel swept 0..15 (SEL_W=4) -> out = 1<<sel one cycle later; with en=0 -> out=0.
REQ-034 SCAN_UP, div=2, load sel=14 -> idx 14,14,14,15,15,15,0,...; wrap=1 only on the edge where idx becomes 0.
REQ-035 SCAN_DOWN, div=0, from idx=1 -> idx 0, then 15 with wrap=1, then 14.
REQ-036 SCAN_UP, load=1 on the cycle a step is due, sel=5 -> idx=5, no wrap, next step after div+1 cycles.
REQ-037 Scan running, en dropped for 3 cycles then raised -> out=0 while disabled; idx and phase resume unchanged.
REQ-038 reset pulsed mid-scan at idx=9 -> next edge idx=0, out=0; with en=1 after release -> out=0x0001.

Source files
------------

// File: rtl/dec_scan_n.sv
// One-hot decoder with a prescaled up/down scan index.
// DIRECT decodes sel; SCAN_UP/SCAN_DOWN step idx every div+1 enabled cycles; HOLD freezes.
module dec_scan_n #(
   parameter  int SEL_W = 4,
   parameter  int DIV_W = 8,
   localparam int OUT_W = 2 ** SEL_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [SEL_W-1:0] sel,
   input  logic             load,
   input  logic [DIV_W-1:0] div,
   output logic [OUT_W-1:0] out,
   output logic [SEL_W-1:0] idx,
   output logic             wrap
);

   typedef enum logic [1:0] {
      DIRECT    = 2'b00,
      SCAN_UP   = 2'b01,
      SCAN_DOWN = 2'b10,
      HOLD      = 2'b11
   } mode_t;

   localparam logic [OUT_W-1:0] ONE = OUT_W'(1);

   logic [DIV_W-1:0] pre, pre_n;
   logic [SEL_W-1:0] idx_n;
   logic [OUT_W-1:0] out_n;
   logic             wrap_n;
   mode_t            pmode, pmode_n;
   logic             seen, seen_n;
   logic             mode_chg;
   logic             up;

   // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      idx_n    = idx;
      pre_n    = pre;
      out_n    = '0;
      wrap_n   = 1'b0;
      pmode_n  = pmode;
      seen_n   = seen;
      mode_chg = 1'b0;
      up       = (mode_t'(mode) == SCAN_UP);
      if (en) begin
         seen_n   = 1'b1;
         pmode_n  = mode_t'(mode);
         // The first enabled cycle after reset has no predecessor to compare against.
         mode_chg = seen && (mode_t'(mode) != pmode);
         case (mode_t'(mode))
            DIRECT: begin
               idx_n = sel;
               pre_n = '0;
            end
            SCAN_UP, SCAN_DOWN: begin
               if (load) begin
                  idx_n = sel;
                  pre_n = '0;
               end else if (mode_chg) begin
                  pre_n = '0;
               end else if (pre >= div) begin
                  // >= rather than == so a div lowered mid-period still steps immediately.
                  pre_n  = '0;
                  idx_n  = up ? idx + 1'b1 : idx - 1'b1;
                  wrap_n = (SEL_W == 1) || (up ? (idx == '1) : (idx == '0));
               end else begin
                  pre_n = pre + 1'b1;
               end
            end
            HOLD: begin
               if (mode_chg) pre_n = '0;
            end
         endcase
         out_n = ONE << idx_n;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         idx   <= '0;
         pre   <= '0;
         out   <= '0;
         wrap  <= 1'b0;
         pmode <= DIRECT;
         seen  <= 1'b0;
      end else begin
         idx   <= idx_n;
         pre   <= pre_n;
         out   <= out_n;
         wrap  <= wrap_n;
         pmode <= pmode_n;
         seen  <= seen_n;
      end
   end

endmodule
